alu_result_stage: RTL
=====================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: DEPTH, 2, skid-buffer entries (fixed at 2; other values unsupported).
REQ-002 Parameter: CNT_W, 16, width of retired-op counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU result valid.
REQ-006 in_ready  output  1  stage can accept; registered, equals "not full".
REQ-007 in_result  input  32  ALU otp.
REQ-008 in_zero  input  1  ALU zero flag.
REQ-009 in_overflow  input  1  ALU overflow flag.
REQ-010 in_alufn  input  6  opcode that produced the result.
REQ-011 in_rd  input  5  destination register index.
REQ-012 out_valid  output  1  writeback entry available.
REQ-013 out_ready  input  1  register-file write port accepts.
REQ-014 out_result, out_zero, out_rd  output  32/1/5  head-entry fields.
REQ-015 out_we  output  1  head entry commits a register write.
REQ-016 flush  input  1  discard all buffered entries.
REQ-017 exc_ovf  output  1  sticky arithmetic-overflow exception.
REQ-018 exc_rd  output  5  rd of first overflowing op since last clear.
REQ-019 exc_clear  input  1  clears exc_ovf and exc_rd.
REQ-020 retired  output  CNT_W  count of entries accepted downstream.

Function
REQ-021 Accept occurs when in_valid && in_ready; emit occurs when out_valid && out_ready.
REQ-022 FSM states EMPTY, ONE, TWO; accept-only advances one state, emit-only retreats one, both (or neither) holds.
REQ-023 in_ready = 1 in EMPTY and ONE, 0 in TWO; out_valid = 1 in ONE and TWO.
REQ-024 Latency: accepted entry visible on outputs the cycle after accept when stage was EMPTY; FIFO order always preserved.
REQ-025 Simultaneous accept and emit in ONE: head replaced by incoming entry, state stays ONE; in TWO accept impossible (in_ready=0).
REQ-026 out_* fields hold stable while out_valid && !out_ready.
REQ-027 Trap rule: entry with alufn in {000000 ADD, 000001 SUB} and in_overflow=1 is tagged trapped at accept.
REQ-028 out_we = out_valid && !trapped && (out_rd != 0).
REQ-029 exc_ovf sets on emit of a trapped entry; exc_rd captured only if exc_ovf was 0 before that cycle.
REQ-030 exc_clear and trapped emit in same cycle: set wins, exc_rd takes new entry's rd.
REQ-031 retired increments by 1 on every emit (trapped included); wraps 2^CNT_W-1 -> 0.
REQ-032 flush: next state EMPTY, buffered entries dropped, no emit counted that cycle even if out_ready=1; accept that cycle is discarded; exc_ovf and retired unaffected.
REQ-033 Unknown alufn codes pass through unchanged, never trapped.

Reset
REQ-034 During rst_n=0: state EMPTY, in_ready=0 (asserts the first cycle after release), out_valid=0, out_we=0, out_result=0, out_zero=0, out_rd=0, exc_ovf=0, exc_rd=0, retired=0.
REQ-035 Reset asserted mid-operation discards all entries immediately, no partial emit.

Structure
REQ-036 Shared package holds alufn opcode constants (ADD, SUB, MUL, AND, OR, XOR, SLL, SRL, SLT) and the FSM state encoding.
REQ-037 One sub-module: wb_entry_reg (one buffer slot: result, zero, rd, trapped with load enable); instantiated twice.

Verification
REQ-038 Reset release, in_valid=1 result 0x00000005 rd=3 ADD, out_ready=1 -> next cycle out_valid=1, out_result=5, out_we=1, retired=1 after emit.
REQ-039 out_ready=0, three back-to-back valids -> in_ready=0 after two accepts, third held; out_ready=1 releases in order 1,2,3.
REQ-040 ADD 0x7FFFFFFF+1 with in_overflow=1 rd=7 -> out_we=0, exc_ovf=1, exc_rd=7; second overflow rd=9 keeps exc_rd=7; exc_clear -> 0.
REQ-041 rd=0 valid AND result -> out_valid=1, out_we=0; MUL with in_overflow=1 -> not trapped, out_we=1.
REQ-042 State TWO, flush=1 with out_ready=1 -> next cycle out_valid=0, retired unchanged.
REQ-043 Preload retired to 0xFFFF via 65535 emits, one more emit -> retired=0x0000.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result/writeback stage: opcode constants,
// FSM state encoding and the overflow trap rule.
package alu_result_stage_pkg;

    localparam logic [5:0] ALUFN_ADD = 6'b000000;
    localparam logic [5:0] ALUFN_SUB = 6'b000001;
    localparam logic [5:0] ALUFN_MUL = 6'b000010;
    localparam logic [5:0] ALUFN_AND = 6'b011000;
    localparam logic [5:0] ALUFN_OR  = 6'b011110;
    localparam logic [5:0] ALUFN_XOR = 6'b010110;
    localparam logic [5:0] ALUFN_SLL = 6'b100000;
    localparam logic [5:0] ALUFN_SRL = 6'b100001;
    localparam logic [5:0] ALUFN_SLT = 6'b110101;

    // Encoding equals buffer occupancy, which the ready logic relies on.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic is_trap(input logic [5:0] alufn, input logic ovf);
        return ovf && ((alufn == ALUFN_ADD) || (alufn == ALUFN_SUB));
    endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// One writeback buffer slot: result, zero flag, destination and trap tag.
module wb_entry_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d_result,
    input  logic        d_zero,
    input  logic [4:0]  d_rd,
    input  logic        d_trapped,
    output logic [31:0] q_result,
    output logic        q_zero,
    output logic [4:0]  q_rd,
    output logic        q_trapped
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_result  <= '0;
            q_zero    <= 1'b0;
            q_rd      <= '0;
            q_trapped <= 1'b0;
        end else if (load) begin
            q_result  <= d_result;
            q_zero    <= d_zero;
            q_rd      <= d_rd;
            q_trapped <= d_trapped;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer between the ALU and the register-file write port,
// with overflow trapping, sticky exception capture and a retired-op counter.
//   state    | meaning
//   ST_EMPTY | no buffered entry
//   ST_ONE   | head slot valid
//   ST_TWO   | head and tail slots valid, upstream stalled
import alu_result_stage_pkg::*;

module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_zero,
    input  logic             in_overflow,
    input  logic [5:0]       in_alufn,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_we,
    input  logic             flush,
    output logic             exc_ovf,
    output logic [4:0]       exc_rd,
    input  logic             exc_clear,
    output logic [CNT_W-1:0] retired
);

    state_t      state, state_nxt;
    logic        accept, emit;
    logic        head_load, head_from_in, tail_load;
    logic        in_trapped;

    logic [31:0] head_result, tail_result, head_d_result;
    logic        head_zero, tail_zero, head_d_zero;
    logic [4:0]  head_rd, tail_rd, head_d_rd;
    logic        head_trapped, tail_trapped, head_d_trapped;

    assign in_trapped = is_trap(in_alufn, in_overflow);
    assign out_valid  = (state != ST_EMPTY);
    assign accept     = in_valid && in_ready;
    // A flushed cycle never counts as an emit, even with out_ready high.
    assign emit       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= ({30'd0, state_nxt} < DEPTH);
        end
    end

    always_comb begin
        state_nxt    = state;
        head_load    = 1'b0;
        head_from_in = 1'b1;
        tail_load    = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_TWO;
                        tail_load = 1'b1;
                    end else if (emit) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        state_nxt    = ST_ONE;
                        head_load    = 1'b1;
                        head_from_in = 1'b0;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign head_d_result  = head_from_in ? in_result  : tail_result;
    assign head_d_zero    = head_from_in ? in_zero    : tail_zero;
    assign head_d_rd      = head_from_in ? in_rd      : tail_rd;
    assign head_d_trapped = head_from_in ? in_trapped : tail_trapped;

    wb_entry_reg u_head (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (head_load),
        .d_result  (head_d_result),
        .d_zero    (head_d_zero),
        .d_rd      (head_d_rd),
        .d_trapped (head_d_trapped),
        .q_result  (head_result),
        .q_zero    (head_zero),
        .q_rd      (head_rd),
        .q_trapped (head_trapped)
    );

    wb_entry_reg u_tail (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tail_load),
        .d_result  (in_result),
        .d_zero    (in_zero),
        .d_rd      (in_rd),
        .d_trapped (in_trapped),
        .q_result  (tail_result),
        .q_zero    (tail_zero),
        .q_rd      (tail_rd),
        .q_trapped (tail_trapped)
    );

    assign out_result = head_result;
    assign out_zero   = head_zero;
    assign out_rd     = head_rd;
    assign out_we     = out_valid && !head_trapped && (head_rd != 5'd0);

    // A trapped emit beats a simultaneous clear and then records its own rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_ovf <= 1'b0;
            exc_rd  <= '0;
        end else if (emit && head_trapped) begin
            exc_ovf <= 1'b1;
            if (!exc_ovf || exc_clear) begin
                exc_rd <= head_rd;
            end
        end else if (exc_clear) begin
            exc_ovf <= 1'b0;
            exc_rd  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (emit) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
